// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame constants and counter widths.
// Used by the receiver now and by the planned uart_tx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int unsigned OS_DEF      = 16;
  localparam int unsigned DBIT_DEF    = 8;
  localparam int unsigned SB_TICK_DEF = 16;

  // Bits needed to hold a count 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned S_W_DEF = cnt_w(SB_TICK_DEF);
  localparam int unsigned N_W_DEF = cnt_w(DBIT_DEF);

endpackage

// File: rtl/rx_sync_edge.sv
// Two-flop synchroniser for the asynchronous rx pin, idle-high on reset,
// plus a registered falling-edge strobe aligned with the synchronised level.
module rx_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic rx_meta;

  // fall is computed from the previous rx_s and the value about to enter rx_s.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      fall    <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      fall    <= rx_s & ~rx_meta;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampling 8N1 UART receiver with framing status.
// Optional parity stage compiled in with UART_RX_PARITY_EN (adds PARITY_ODD parameter).
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = DBIT_DEF,
  parameter int unsigned OS      = OS_DEF,
  parameter int unsigned SB_TICK = SB_TICK_DEF
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit          PARITY_ODD = 1'b0
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err,
  output logic            busy
);

  localparam int unsigned S_W = cnt_w((SB_TICK > OS) ? SB_TICK : OS);
  localparam int unsigned N_W = cnt_w(DBIT);

  uart_state_t     state;
  logic [S_W-1:0]  s;
  logic [N_W-1:0]  n;
  logic [DBIT-1:0] shreg;
  logic            stop_r;
  logic            stop_val_c;
  logic            rx_s;
  logic            fall;

  rx_sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  // Stop-bit level at its midpoint; used directly when the frame ends on that same tick.
  assign stop_val_c = (s == S_W'(OS - 1)) ? rx_s : stop_r;

`ifdef UART_RX_PARITY_EN
  logic par_r;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      shreg        <= '0;
      stop_r       <= 1'b0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_r        <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            s     <= '0;
            busy  <= 1'b1;
          end
        end
        // Half a bit in: a line that is high again was only a glitch.
        START: begin
          if (s_tick) begin
            if (s == S_W'(OS / 2 - 1)) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              s <= s + S_W'(1);
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == S_W'(OS - 1)) begin
              s     <= '0;
              shreg <= {rx_s, shreg[DBIT-1:1]};
              if (n == N_W'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n <= n + N_W'(1);
              end
            end else begin
              s <= s + S_W'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (s == S_W'(OS - 1)) begin
              s     <= '0;
              par_r <= (^shreg) ^ rx_s ^ PARITY_ODD;
              state <= STOP;
            end else begin
              s <= s + S_W'(1);
            end
          end
        end
`endif
        STOP: begin
          if (s_tick) begin
            if (s == S_W'(OS - 1)) begin
              stop_r <= rx_s;
            end
            if (s == S_W'(SB_TICK - 1)) begin
              rx_done_tick <= 1'b1;
              dout         <= shreg;
              frame_err    <= ~stop_val_c;
`ifdef UART_RX_PARITY_EN
              parity_err   <= par_r;
`endif
              s            <= '0;
              state        <= IDLE;
              busy         <= 1'b0;
            end else begin
              s <= s + S_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          s     <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: frames are described at the line level and the
// expected word and flags come from the framing rules, checked on each rx_done_tick.
module tb_uart_rx_os;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  uart_rx_os dut (
    .clk          (clk),
    .rst          (rst),
    .s_tick       (s_tick),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .parity_err   (parity_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      s_tick = (c == 0);
      c = (c + 1) % TICK_DIV;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic hold(input logic v, input int unsigned clks);
    rx = v;
    repeat (clks) @(negedge clk);
  endtask

  // One frame on the line; the expected result is queued before the start bit.
  task automatic send(input logic [7:0] d, input logic stop_v, input logic pbit);
    exp_t e;
    e.data = d;
    e.ferr = ~stop_v;
    e.perr = PAR_EN ? ((^d) ^ pbit) : 1'b0;
    sb.push_back(e);
    hold(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) hold(d[i], BIT_CLKS);
    if (PAR_EN) hold(pbit, BIT_CLKS);
    hold(stop_v, BIT_CLKS);
    rx = 1'b1;
  endtask

  initial begin : main
    logic [7:0] d;
    logic       stp;
    logic       pb;
    logic [7:0] v;
    exp_t       e;
    int unsigned gap;

    rx  = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_done", rx_done_tick, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (rx_done_tick) begin
          if (sb.size() == 0) begin
            chk("unexpected_pulse", 1, 0);
          end else begin
            exp_t x;
            x = sb.pop_front();
            chk("dout", dout, x.data);
            chk("frame_err", frame_err, x.ferr);
            chk("parity_err", parity_err, x.perr);
          end
        end
      end
    join_none

    hold(1'b1, BIT_CLKS);
    send(8'hA5, 1'b1, ^8'hA5);
    hold(1'b1, BIT_CLKS);

    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    hold(1'b1, BIT_CLKS);

    for (int k = 0; k < 12; k++) begin
      d   = 8'($urandom);
      stp = ($urandom_range(0, 7) != 0);
      pb  = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
      send(d, stp, pb);
      gap = stp ? $urandom_range(0, 2) : $urandom_range(1, 2);
      hold(1'b1, gap * BIT_CLKS);
    end
    hold(1'b1, BIT_CLKS);

    // Glitch shorter than half a bit must not start a frame.
    rx = 1'b0;
    repeat (6) @(negedge clk);
    chk("glitch_busy", busy, 1);
    repeat (6) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    chk("glitch_idle", busy, 0);
    hold(1'b1, BIT_CLKS);

    send(8'h5A, 1'b1, ^8'h5A);
    hold(1'b1, BIT_CLKS);

    // Reset during bit 4 of 0x3C.
    v = 8'h3C;
    hold(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) hold(v[i], BIT_CLKS);
    rx = v[4];
    repeat (32) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_dout", dout, 0);
    chk("midrst_done", rx_done_tick, 0);
    chk("midrst_ferr", frame_err, 0);
    chk("midrst_perr", parity_err, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    hold(1'b1, 2 * BIT_CLKS);
    send(8'h3C, 1'b1, ^8'h3C);
    hold(1'b1, BIT_CLKS);

    // Break: one all-zero frame with a framing error, then silence.
    e.data = 8'h00;
    e.ferr = 1'b1;
    e.perr = 1'b0;
    sb.push_back(e);
    hold(1'b0, 20 * BIT_CLKS);
    hold(1'b1, 3 * BIT_CLKS);

    if (PAR_EN) begin
      send(8'h07, 1'b1, 1'b1);
      hold(1'b1, BIT_CLKS);
      send(8'h07, 1'b1, 1'b0);
      hold(1'b1, BIT_CLKS);
    end

    for (int i = 0; i < 4000 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    repeat (200) @(negedge clk);
    disable fork;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
